// File: rtl/multi_symbol_order_engine.sv
// multi_symbol_order_engine: per-symbol BBO/prediction tracking, spread
// qualification, round-robin order issue with cooldown, in-flight limit, kill.
// Optional macro TRADE_STATS_EN enables the accepted-order counter.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   bbo_valid/sym/bid/ask      best bid/offer update
//   pred_valid/sym/bit         prediction update
//   kill                       level, blocks new grants
//   order_valid/ready/sym/price  order offer (valid/ready)
//   ack_valid                  one order completed
//   inflight, ack_err          outstanding count, sticky underflow flag
//   stat_orders                accepted-order count (0 without TRADE_STATS_EN)
module multi_symbol_order_engine #(
    parameter int NUM_SYM       = 4,
    parameter int PRICE_W       = 32,
    parameter int SPREAD_THRESH = 5,
    parameter int COOLDOWN_CYC  = 16,
    parameter int MAX_INFLIGHT  = 8,
    localparam int SYM_W = $clog2(NUM_SYM),
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bbo_valid,
    input  logic [SYM_W-1:0]   bbo_sym,
    input  logic [PRICE_W-1:0] bbo_bid,
    input  logic [PRICE_W-1:0] bbo_ask,
    input  logic               pred_valid,
    input  logic [SYM_W-1:0]   pred_sym,
    input  logic               pred_bit,
    input  logic               kill,
    output logic               order_valid,
    input  logic               order_ready,
    output logic [SYM_W-1:0]   order_sym,
    output logic [PRICE_W-1:0] order_price,
    input  logic               ack_valid,
    output logic [CNT_W-1:0]   inflight,
    output logic               ack_err,
    output logic [31:0]        stat_orders
);

    localparam int CD_W = $clog2(COOLDOWN_CYC + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    localparam logic [PRICE_W-1:0] THRESH  = PRICE_W'(SPREAD_THRESH);
    localparam logic [CD_W-1:0]    CD_INIT = CD_W'(COOLDOWN_CYC);
    localparam logic [CNT_W-1:0]   MAX_CNT = CNT_W'(MAX_INFLIGHT);

    logic [PRICE_W-1:0] bid_q [NUM_SYM];
    logic [PRICE_W-1:0] ask_q [NUM_SYM];
    logic [CD_W-1:0]    cd_q  [NUM_SYM];
    logic [NUM_SYM-1:0] bbo_ok_q;
    logic [NUM_SYM-1:0] pred_q;

    logic [0:0]         state_q;
    logic [SYM_W-1:0]   rr_q;
    logic               ov_q;
    logic [SYM_W-1:0]   osym_q;
    logic [PRICE_W-1:0] oprice_q;
    logic [CNT_W-1:0]   infl_q;
    logic               err_q;

    logic [NUM_SYM-1:0] cand;
    logic [PRICE_W-1:0] spread [NUM_SYM];
    logic               grant_hit;
    logic [SYM_W-1:0]   grant_sym;
    logic [SYM_W-1:0]   idx;
    logic               can_issue;
    logic               hs;

    // The ask>bid term guards the subtraction so a crossed
    // book cannot wrap into a huge positive spread.
    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_SYM; i++) begin
            spread[i] = ask_q[i] - bid_q[i];
            cand[i]   = bbo_ok_q[i] & pred_q[i]
                      & (ask_q[i] > bid_q[i])
                      & (spread[i] > THRESH)
                      & (cd_q[i] == '0);
        end
    end

    // Scan offsets high to low so the smallest offset from
    // rr_q is the one left standing.
    always_comb begin
        grant_hit = 1'b0;
        grant_sym = '0;
        idx       = '0;
        for (int k = NUM_SYM - 1; k >= 0; k--) begin
            idx = rr_q + SYM_W'(k);
            if (cand[idx]) begin
                grant_hit = 1'b1;
                grant_sym = idx;
            end
        end
    end

    assign can_issue = (state_q == ST_IDLE) & grant_hit
                     & ~kill & (infl_q < MAX_CNT);
    assign hs = (state_q == ST_ISSUE) & ov_q & order_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ov_q     <= 1'b0;
            osym_q   <= '0;
            oprice_q <= '0;
            rr_q     <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (can_issue) begin
                        state_q  <= ST_ISSUE;
                        ov_q     <= 1'b1;
                        osym_q   <= grant_sym;
                        oprice_q <= ask_q[grant_sym];
                    end
                end
                ST_ISSUE: begin
                    if (order_ready) begin
                        state_q <= ST_IDLE;
                        ov_q    <= 1'b0;
                        rr_q    <= osym_q + SYM_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ov_q    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bbo_ok_q <= '0;
            pred_q   <= '0;
            for (int i = 0; i < NUM_SYM; i++) begin
                bid_q[i] <= '0;
                ask_q[i] <= '0;
                cd_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SYM; i++) begin
                if (bbo_valid && bbo_sym == SYM_W'(i)) begin
                    bid_q[i]    <= bbo_bid;
                    ask_q[i]    <= bbo_ask;
                    bbo_ok_q[i] <= 1'b1;
                end
                // An accepted order consumes the prediction unless
                // a fresh one for the same symbol lands this cycle.
                if (hs && osym_q == SYM_W'(i)) begin
                    if (pred_valid && pred_sym == SYM_W'(i))
                        pred_q[i] <= pred_bit;
                    else
                        pred_q[i] <= 1'b0;
                    cd_q[i] <= CD_INIT;
                end else begin
                    if (pred_valid && pred_sym == SYM_W'(i))
                        pred_q[i] <= pred_bit;
                    if (cd_q[i] != '0)
                        cd_q[i] <= cd_q[i] - CD_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (hs && !ack_valid) begin
                infl_q <= infl_q + CNT_W'(1);
            end else if (ack_valid && !hs) begin
                if (infl_q == '0)
                    err_q <= 1'b1;
                else
                    infl_q <= infl_q - CNT_W'(1);
            end
        end
    end

`ifdef TRADE_STATS_EN
    logic [31:0] stat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else if (hs && stat_q != 32'hFFFF_FFFF) begin
            stat_q <= stat_q + 32'd1;
        end
    end

    assign stat_orders = stat_q;
`else
    assign stat_orders = 32'd0;
`endif

    assign order_valid = ov_q;
    assign order_sym   = osym_q;
    assign order_price = oprice_q;
    assign inflight    = infl_q;
    assign ack_err     = err_q;

endmodule

// File: tb/tb_multi_symbol_order_engine.sv
// tb_multi_symbol_order_engine: directed scenarios plus random stimulus,
// checked every cycle against a transaction-level reference model.
module tb_multi_symbol_order_engine;

    localparam int N     = 4;
    localparam int THR   = 5;
    localparam int CD    = 16;
    localparam int MAXI  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bbo_valid;
    logic [1:0]  bbo_sym;
    logic [31:0] bbo_bid;
    logic [31:0] bbo_ask;
    logic        pred_valid;
    logic [1:0]  pred_sym;
    logic        pred_bit;
    logic        kill;
    logic        order_valid;
    logic        order_ready;
    logic [1:0]  order_sym;
    logic [31:0] order_price;
    logic        ack_valid;
    logic [3:0]  inflight;
    logic        ack_err;
    logic [31:0] stat_orders;

    multi_symbol_order_engine dut (
        .clk(clk), .rst_n(rst_n),
        .bbo_valid(bbo_valid), .bbo_sym(bbo_sym),
        .bbo_bid(bbo_bid), .bbo_ask(bbo_ask),
        .pred_valid(pred_valid), .pred_sym(pred_sym),
        .pred_bit(pred_bit), .kill(kill),
        .order_valid(order_valid), .order_ready(order_ready),
        .order_sym(order_sym), .order_price(order_price),
        .ack_valid(ack_valid), .inflight(inflight),
        .ack_err(ack_err), .stat_orders(stat_orders)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: books as plain integers, the offer as a
    // pending transaction, cooldown as "cycles left".
    longint m_bid [N];
    longint m_ask [N];
    bit     m_ok  [N];
    bit     m_pred[N];
    int     m_cd  [N];
    bit     m_ov;
    int     m_sym;
    longint m_price;
    int     m_rr;
    int     m_infl;
    bit     m_err;
    longint m_stat;
    int     acc_q[$];

    function automatic void model_reset();
        for (int s = 0; s < N; s++) begin
            m_bid[s] = 0; m_ask[s] = 0;
            m_ok[s] = 0; m_pred[s] = 0; m_cd[s] = 0;
        end
        m_ov = 0; m_sym = 0; m_price = 0; m_rr = 0;
        m_infl = 0; m_err = 0; m_stat = 0;
    endfunction

    function automatic bit m_cand(int s);
        return m_ok[s] && m_pred[s] && m_cd[s] == 0
            && (m_ask[s] - m_bid[s]) > THR;
    endfunction

    function automatic void model_step();
        bit     hs = m_ov && order_ready;
        bit     g = 0;
        int     gs = 0;
        longint gp;
        if (!m_ov && !kill && m_infl < MAXI)
            for (int k = 0; k < N; k++)
                if (!g && m_cand((m_rr + k) % N)) begin
                    g = 1; gs = (m_rr + k) % N;
                end
        gp = m_ask[gs];
        for (int s = 0; s < N; s++)
            if (m_cd[s] > 0) m_cd[s]--;
        if (bbo_valid) begin
            m_bid[bbo_sym] = bbo_bid;
            m_ask[bbo_sym] = bbo_ask;
            m_ok[bbo_sym]  = 1;
        end
        if (pred_valid) m_pred[pred_sym] = pred_bit;
        if (hs) begin
            m_cd[m_sym] = CD;
            if (!(pred_valid && pred_sym == m_sym))
                m_pred[m_sym] = 0;
            m_rr = (m_sym + 1) % N;
            m_ov = 0;
            if (m_stat < 64'hFFFF_FFFF) m_stat++;
        end
        if (hs && !ack_valid) m_infl++;
        else if (ack_valid && !hs) begin
            if (m_infl == 0) m_err = 1;
            else m_infl--;
        end
        if (g) begin
            m_ov = 1; m_sym = gs; m_price = gp;
        end
    endfunction

    function automatic longint exp_stat();
`ifdef TRADE_STATS_EN
        return m_stat;
`else
        return 0;
`endif
    endfunction

    task automatic compare_all();
        chk("order_valid", order_valid, m_ov);
        if (m_ov) begin
            chk("order_sym", order_sym, m_sym);
            chk("order_price", order_price, m_price);
        end
        chk("inflight", inflight, m_infl);
        chk("ack_err", ack_err, m_err);
        chk("stat_orders", stat_orders, exp_stat());
    endtask

    // Inputs are set after a falling edge; one rising edge
    // is consumed and outputs are compared on the next fall.
    task automatic tick();
        if (order_valid && order_ready) acc_q.push_back(order_sym);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic quiet();
        bbo_valid = 0; pred_valid = 0;
        ack_valid = 0; kill = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic set_bbo(input int s, input int b, input int a);
        bbo_valid = 1; bbo_sym = 2'(s);
        bbo_bid = 32'(b); bbo_ask = 32'(a);
        tick();
        bbo_valid = 0;
    endtask

    task automatic set_pred(input int s, input bit b);
        pred_valid = 1; pred_sym = 2'(s); pred_bit = b;
        tick();
        pred_valid = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        quiet();
        order_ready = 0;
        model_reset();
        acc_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", order_valid, 0);
        chk("rst_sym", order_sym, 0);
        chk("rst_price", order_price, 0);
        chk("rst_infl", inflight, 0);
        chk("rst_err", ack_err, 0);
        chk("rst_stat", stat_orders, 0);
        rst_n = 1;
    endtask

    initial begin
        bbo_sym = 0; bbo_bid = 0; bbo_ask = 0;
        pred_sym = 0; pred_bit = 0;
        @(negedge clk);
        do_reset();

        // Basic latency: pred in cycle N -> offer in N+2.
        set_bbo(1, 100, 110);
        pred_valid = 1; pred_sym = 1; pred_bit = 1;
        tick();
        pred_valid = 0;
        chk("lat_n1", order_valid, 0);
        tick();
        chk("lat_n2", order_valid, 1);
        chk("lat_sym", order_sym, 1);
        chk("lat_price", order_price, 110);
        order_ready = 1;
        idle(3);

        // Spread equal to threshold and crossed book.
        set_bbo(2, 100, 105);
        set_pred(2, 1);
        idle(4);
        chk("thr_equal", order_valid, 0);
        set_bbo(3, 110, 100);
        set_pred(3, 1);
        idle(4);
        chk("crossed", order_valid, 0);

        // Two simultaneous candidates, round-robin order.
        do_reset();
        kill = 1;
        set_bbo(0, 50, 60);
        set_bbo(2, 50, 70);
        set_pred(0, 1);
        set_pred(2, 1);
        kill = 0;
        order_ready = 1;
        idle(8);
        chk("rr_count", acc_q.size(), 2);
        if (acc_q.size() == 2) begin
            chk("rr_first", acc_q[0], 0);
            chk("rr_second", acc_q[1], 2);
        end
        idle(20);
        set_pred(0, 1);
        idle(4);
        chk("rr_rearm", acc_q[$], 0);

        // Offer held under backpressure, kill and bbo churn.
        order_ready = 0;
        set_bbo(3, 10, 30);
        set_pred(3, 1);
        idle(2);
        for (int i = 0; i < 10; i++) begin
            kill = i[0];
            bbo_valid = 1; bbo_sym = 3;
            bbo_bid = 32'(i); bbo_ask = 32'(200 + i);
            tick();
            chk("hold_valid", order_valid, 1);
            chk("hold_sym", order_sym, 3);
            chk("hold_price", order_price, 30);
        end
        quiet();
        order_ready = 1;
        idle(2);

        // Cooldown: re-arm sym3 right after its order.
        set_pred(3, 1);
        idle(8);
        chk("cd_block", order_valid, 0);
        idle(12);
        chk("cd_release", acc_q[$], 3);

        // In-flight limit, release by ack, underflow.
        do_reset();
        for (int s = 0; s < N; s++) set_bbo(s, 0, 20);
        order_ready = 1;
        for (int c = 0; c < 90; c++) begin
            pred_valid = 1; pred_sym = 2'(c % N); pred_bit = 1;
            tick();
        end
        chk("lim_full", inflight, MAXI);
        chk("lim_blocked", order_valid, 0);
        chk("lim_accepted", acc_q.size(), MAXI);
        ack_valid = 1;
        tick();
        ack_valid = 0;
        idle(4);
        chk("lim_resume", acc_q.size(), MAXI + 1);
        quiet();
        kill = 1;
        ack_valid = 1;
        idle(12);
        chk("ack_underflow", ack_err, 1);
        chk("ack_zero", inflight, 0);
        quiet();

        // Reset while an order is offered.
        do_reset();
        set_bbo(1, 100, 120);
        set_pred(1, 1);
        idle(2);
        chk("mid_offer", order_valid, 1);
        rst_n = 0;
        #1;
        chk("mid_valid", order_valid, 0);
        chk("mid_sym", order_sym, 0);
        chk("mid_price", order_price, 0);
        chk("mid_infl", inflight, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        order_ready = 1;
        idle(6);
        chk("mid_none", acc_q.size(), 0);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            automatic int b = 90 + int'($urandom_range(0, 19));
            bbo_valid   = ($urandom_range(0, 2) == 0);
            bbo_sym     = 2'($urandom_range(0, 3));
            bbo_bid     = 32'(b);
            bbo_ask     = 32'(b - 3 + int'($urandom_range(0, 15)));
            pred_valid  = $urandom_range(0, 1) == 1;
            pred_sym    = 2'($urandom_range(0, 3));
            pred_bit    = ($urandom_range(0, 3) != 0);
            kill        = ($urandom_range(0, 9) == 0);
            order_ready = ($urandom_range(0, 3) != 0);
            ack_valid   = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
